// File: rtl/spi_opcode_slave.sv
// spi_opcode_slave
// SPI (mode 0) slave sitting between the Raspberry Pi and the game logic.
// A frame is OPCODE_W opcode bits from the Pi followed by REPLY_W reply bits
// back to the Pi, all MSB first, inside a single ce_n-low window. Every SPI
// pin is oversampled in the clk domain, so clk must run at least 8x sck.
module spi_opcode_slave #(
    parameter int OPCODE_W    = 8,
    parameter int REPLY_W     = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                ce_n,
    input  logic                sdi,
    input  logic [REPLY_W-1:0]  reply,
    output logic                sdo,
    output logic [OPCODE_W-1:0] activeopcode,
    output logic                pulse_load,
    output logic                busy
);

    // One counter serves both the opcode and the reply phase, so it is
    // sized for whichever of the two is longer.
    localparam int MAX_W = (OPCODE_W > REPLY_W) ? OPCODE_W : REPLY_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] LAST_OPC_BIT = CNT_W'(OPCODE_W - 1);
    localparam logic [CNT_W-1:0] LAST_REP_BIT = CNT_W'(REPLY_W - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPCODE  = 3'd1,
        CAPTURE = 3'd2,
        REPLY   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Synchroniser chains; the last stage of each is the usable sample.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;

    // One extra delayed copy of sck and ce_n for edge detection.
    logic sck_d;
    logic ce_d;

    logic sck_s;
    logic ce_s;
    logic sdi_s;

    logic sck_rise;
    logic sck_fall;
    logic ce_rise;
    logic ce_fall;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [OPCODE_W-1:0]  shift_in;
    logic [REPLY_W-1:0]   shift_out;
    logic [OPCODE_W-1:0]  opcode_next;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ce_s  = ce_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ce_rise  = ce_s & ~ce_d;
    assign ce_fall  = ~ce_s & ce_d;

    // Opcode register as it will look once the bit on the current rise is in.
    assign opcode_next = {shift_in[OPCODE_W-2:0], sdi_s};

    // Bring the asynchronous SPI pins into the clk domain and keep the
    // previous synchronised sck/ce_n for edge detection. Clearing the chains
    // on reset means a ce_n that is already low never looks like a new
    // falling edge, so an interrupted frame is ignored until ce_n cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            ce_sync  <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
            ce_d     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            ce_sync  <= {ce_sync[SYNC_STAGES-2:0], ce_n};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            ce_d     <= ce_sync[SYNC_STAGES-1];
        end
    end

    // Frame sequencer: opcode shift-in, one-cycle reply capture, reply
    // shift-out, then drain until the Pi releases ce_n. A ce_n rise takes
    // priority over any sck edge seen on the same clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_in     <= '0;
            shift_out    <= '0;
            activeopcode <= '0;
            sdo          <= 1'b0;
            pulse_load   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // pulse_load is only ever raised on the way into CAPTURE.
            pulse_load <= 1'b0;

            if ((state != IDLE) && ce_rise) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sdo     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sdo <= 1'b0;
                        if (ce_fall) begin
                            state    <= OPCODE;
                            bit_cnt  <= '0;
                            shift_in <= '0;
                            busy     <= 1'b1;
                        end
                    end

                    OPCODE: begin
                        if (sck_rise) begin
                            shift_in <= opcode_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_OPC_BIT) begin
                                // The game logic sees the new opcode from
                                // the next cycle, which is CAPTURE.
                                activeopcode <= opcode_next;
                                pulse_load   <= 1'b1;
                                state        <= CAPTURE;
                            end
                        end
                    end

                    CAPTURE: begin
                        // reply is combinational in activeopcode, which
                        // was updated on the previous edge.
                        shift_out <= reply;
                        bit_cnt   <= '0;
                        state     <= REPLY;
                    end

                    REPLY: begin
                        if (sck_fall) begin
                            // The first fall here ends the last opcode bit
                            // and therefore presents the reply MSB.
                            sdo       <= shift_out[REPLY_W-1];
                            shift_out <= {shift_out[REPLY_W-2:0], 1'b0};
                        end else if (sck_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_REP_BIT) begin
                                state <= DRAIN;
                                sdo   <= 1'b0;
                            end
                        end
                    end

                    DRAIN: begin
                        sdo <= 1'b0;
                    end

                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        sdo     <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_opcode_slave.sv
// tb_spi_opcode_slave
// Self-checking bench: plays the Pi (mode 0 master) and the game logic, and
// compares the DUT against a frame-level model of what the Pi should read.
module tb_spi_opcode_slave;

    logic        clk;
    logic        reset;
    logic        sck;
    logic        ce_n;
    logic        sdi;
    logic [23:0] reply;
    logic        sdo;
    logic [7:0]  activeopcode;
    logic        pulse_load;
    logic        busy;

    int checks;
    int errors;
    int pulse_cnt;

    // Model state: what the DUT should currently hold.
    logic [7:0] model_op;
    int         model_pulses;
    logic       reply_by_op;

    spi_opcode_slave #(
        .OPCODE_W    (8),
        .REPLY_W     (24),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .ce_n         (ce_n),
        .sdi          (sdi),
        .reply        (reply),
        .sdo          (sdo),
        .activeopcode (activeopcode),
        .pulse_load   (pulse_load),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game logic reply table.
    function automatic logic [23:0] reply_of(input logic [7:0] op);
        if (op[7:4] == 4'h1)      return 24'h7A5F0F;
        else if (op[7:4] == 4'h2) return 24'hC00000;
        else                      return {op ^ 8'hA5, op, ~op};
    endfunction

    // Game logic: combinational reply, either fixed or opcode-dependent.
    always_comb begin
        if (reply_by_op) reply = reply_of(activeopcode);
        else             reply = 24'hABCDEF;
    end

    // Count every clk cycle in which pulse_load is high.
    always @(negedge clk) begin
        if (pulse_load) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pi side of one ce_n window of ncyc sck cycles with half period h clks.
    // rst_at: cycle at which reset is pulsed (-1 none).
    // ce_at: cycle whose rise coincides with ce_n going high (-1 none).
    task automatic run_frame(input logic [7:0] op, input int ncyc, input int h,
                             input int rst_at, input int ce_at,
                             output logic [63:0] miso);
        miso = '0;
        ce_n = 1'b0;
        wait_clk(h);
        for (int i = 0; i < ncyc; i++) begin
            sdi = (i < 8) ? op[7 - i] : 1'($urandom_range(0, 1));
            if (i == rst_at) begin
                reset = 1'b1;
                wait_clk(1);
                check_val("rst_sdo", 64'(sdo), 64'd0);
                check_val("rst_op", 64'(activeopcode), 64'd0);
                check_val("rst_pulse", 64'(pulse_load), 64'd0);
                check_val("rst_busy", 64'(busy), 64'd0);
                reset = 1'b0;
            end
            wait_clk(h);
            if (i == 0 && rst_at < 0) check_val("busy_mid", 64'(busy), 64'd1);
            miso = {miso[62:0], sdo};
            if (i == ce_at) begin
                sck  = 1'b1;
                ce_n = 1'b1;
                wait_clk(h);
                sck = 1'b0;
                break;
            end
            sck = 1'b1;
            wait_clk(h);
            sck = 1'b0;
        end
        wait_clk(h);
        ce_n = 1'b1;
        wait_clk(8);
    endtask

    // Full frame plus comparison against the model.
    task automatic frame_check(input string tag, input logic [7:0] op, input int ncyc, input int h);
        logic [63:0] miso;
        logic [63:0] exp_miso;
        logic [23:0] rep;
        run_frame(op, ncyc, h, -1, -1, miso);
        if (ncyc >= 8) begin
            model_op     = op;
            model_pulses = model_pulses + 1;
        end
        rep = reply_by_op ? reply_of(op) : 24'hABCDEF;
        exp_miso = '0;
        for (int p = 0; p < ncyc; p++) begin
            exp_miso = {exp_miso[62:0], ((p >= 8) && (p < 32)) ? rep[31 - p] : 1'b0};
        end
        check_val({tag, "_miso"}, miso, exp_miso);
        check_val({tag, "_op"}, 64'(activeopcode), 64'(model_op));
        check_val({tag, "_pulses"}, 64'(pulse_cnt), 64'(model_pulses));
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_sdo"}, 64'(sdo), 64'd0);
    endtask

    initial begin
        logic [63:0] dummy;
        checks       = 0;
        errors       = 0;
        pulse_cnt    = 0;
        model_op     = 8'h00;
        model_pulses = 0;
        reply_by_op  = 1'b0;
        reset        = 1'b1;
        sck          = 1'b0;
        ce_n         = 1'b1;
        sdi          = 1'b0;

        wait_clk(4);
        check_val("reset_op", 64'(activeopcode), 64'd0);
        check_val("reset_sdo", 64'(sdo), 64'd0);
        check_val("reset_pulse", 64'(pulse_load), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        wait_clk(4);

        // Fixed reply 0xABCDEF with opcode 0x10.
        frame_check("fixed", 8'h10, 32, 4);

        // Opcode-dependent reply: capture must follow the opcode update.
        reply_by_op = 1'b1;
        frame_check("op13", 8'h13, 32, 5);
        frame_check("op25", 8'h25, 32, 5);
        frame_check("op10", 8'h10, 32, 4);

        // Abort after 5 opcode bits of 0x20.
        frame_check("abort5", 8'h20, 5, 4);

        // 40 sck cycles in one window: trailing bits read 0.
        frame_check("long40", 8'h10, 40, 4);

        // Reset at reply bit 12: frame discarded, outputs cleared.
        run_frame(8'h10, 32, 4, 20, -1, dummy);
        model_op = 8'h00;
        check_val("postrst_op", 64'(activeopcode), 64'(model_op));
        check_val("postrst_busy", 64'(busy), 64'd0);
        pulse_cnt    = 0;
        model_pulses = 0;
        frame_check("after_rst", 8'h21, 32, 4);

        // ce_n rise together with the completing 8th rise: edge ignored.
        run_frame(8'h37, 32, 4, -1, 7, dummy);
        check_val("ce_win_op", 64'(activeopcode), 64'(model_op));
        check_val("ce_win_pulses", 64'(pulse_cnt), 64'(model_pulses));
        check_val("ce_win_busy", 64'(busy), 64'd0);
        check_val("ce_win_sdo", 64'(sdo), 64'd0);
        frame_check("after_ce", 8'h42, 32, 4);

        // Randomised frames: random opcode, length and sck rate.
        for (int n = 0; n < 24; n++) begin
            frame_check("rand", 8'($urandom_range(0, 255)),
                        int'($urandom_range(1, 40)), int'($urandom_range(4, 8)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_opcode_slave.md
Name: spi_opcode_slave

Overview:
- SPI slave between the Raspberry Pi and the game logic block.
- Receives an opcode byte from the Pi and drives it as activeopcode.
- Captures the game logic's combinational 24-bit reply, issues a one-cycle pulse_load, and shifts the reply back to the Pi in the same frame.
- All SPI pins are oversampled in the clk domain; there is no second clock.

Parameters:
- OPCODE_W, 8, opcode bits received per frame
- REPLY_W, 24, reply bits returned per frame
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2)

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- sck  input  1  SPI clock from Pi, asynchronous, mode 0
- ce_n  input  1  SPI chip enable from Pi, active-low, asynchronous
- sdi  input  1  MOSI from Pi, MSB first
- reply  input  REPLY_W  reply word from game logic, combinational in activeopcode
- sdo  output  1  MISO to Pi, MSB first
- activeopcode  output  OPCODE_W  last fully received opcode
- pulse_load  output  1  one-clk pulse when reply is captured
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: activeopcode=0, sdo=0, pulse_load=0, busy=0, state=IDLE, all shift registers and counters 0.
- Synchronisers: sck, ce_n and sdi each pass through SYNC_STAGES flops.
  - Edges are derived from the synchronised sck: rise=sck_s & ~sck_d, fall=~sck_s & sck_d.
  - Operating requirement: clk frequency >= 8x sck frequency.
- States: IDLE, OPCODE, CAPTURE, REPLY, DRAIN.
- IDLE:
  - sdo=0.
  - Synchronised ce_n falling -> OPCODE; bit counter cleared, shift-in register cleared.
- OPCODE:
  - On each rise: shift sdi_s in at the LSB; counter+1.
  - On the rise that completes OPCODE_W bits: activeopcode <= assembled byte (including the bit just sampled) on that same clk edge; go to CAPTURE.
- CAPTURE (exactly one clk):
  - Shift-out register <= reply, which is now valid for the new activeopcode.
  - pulse_load=1 for this single cycle.
  - Go to REPLY.
- REPLY:
  - On the first fall after CAPTURE (the falling edge that ends bit OPCODE_W-1), sdo <= reply MSB.
  - On each following fall, shift left and drive the next bit.
  - The Pi samples on sck rise.
  - After the rise that samples reply bit 0 (REPLY_W rises counted in this state) -> DRAIN.
- DRAIN:
  - sdo=0; further sck edges ignored.
  - Stay until ce_n rises.
- Frame end:
  - ce_n rising (synchronised) in any non-IDLE state -> IDLE on the next clk; sdo=0.
  - Abort in OPCODE: activeopcode unchanged, no pulse_load.
  - Abort in REPLY: activeopcode keeps the new value; pulse_load has already fired once.
- pulse_load fires at most once per frame and never outside CAPTURE.
- Simultaneous ce_n rise and sck edge on the same clk: ce_n wins and the edge is ignored.
- Reset asserted mid-frame: immediate return to reset values on that clk. A frame in progress is discarded until ce_n goes high and then low again.
- ce_n held low after reset with no falling edge: stay in IDLE.
- Bit ordering: opcode and reply are both MSB first. Frame length is OPCODE_W+REPLY_W = 32 sck cycles.

Test Plan:
- Reset, then frame with opcode 0x10 and reply tied to 0xABCDEF -> activeopcode=0x10 after rise 8; pulse_load high exactly 1 clk; Pi-side sampled MISO bits 9..32 = 0xABCDEF; busy low after ce_n rise.
- Reply driven as a function of opcode (0x1z -> 0x7A5F0F, 0x2z -> 0xC00000); frames 0x13 then 0x25 -> returned 0x7A5F0F then 0xC00000, proving capture occurs after the opcode update.
- ce_n raised after 5 opcode bits of 0x20, with prior activeopcode=0x10 -> activeopcode stays 0x10, no pulse_load, sdo=0, state IDLE.
- 40 sck cycles in one ce_n window with opcode 0x10 -> 24 reply bits correct, bits 33..40 read 0, single pulse_load.
- Reset asserted at reply bit 12 -> all outputs at reset values next clk; the next full frame with opcode 0x21 works normally.
- sck at clk/8 with ce_n rising on the same clk as a sck rise -> edge ignored; returns to IDLE; no spurious shift.
